// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises rx_in, validates start, samples 8 data bits LSB-first at mid-bit, checks stop.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_rx_deserializer #(
    parameter int CLOCKS_PER_BIT = 217,
    parameter int SYNC_STAGES    = 2,
    parameter int PARITY_ODD     = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_complete,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'((CLOCKS_PER_BIT - 1) / 2);

    if (CLOCKS_PER_BIT < 8 || SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_deserializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    rx_state_t              state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       clk_cnt, clk_cnt_next;
    logic [2:0]             bit_idx, bit_idx_next;
    logic [7:0]             shift, shift_next;
    logic [7:0]             byte_next;
    logic                   complete_next, frame_next;
    logic                   tick;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bad, parity_bad_next;
    logic                   perr_q, perr_next;
    localparam logic        PARITY_BIT = (PARITY_ODD != 0);
`endif

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (clk_cnt == LAST_TICK);
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_byte     <= '0;
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad  <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            rx_byte     <= byte_next;
            rx_complete <= complete_next;
            frame_err   <= frame_next;
`ifdef UART_RX_PARITY_EN
            parity_bad  <= parity_bad_next;
            perr_q      <= perr_next;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        clk_cnt_next  = clk_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        byte_next     = rx_byte;
        complete_next = 1'b0;
        frame_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
        perr_next       = 1'b0;
`endif
        unique case (state)
            RX_IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_next = 1'b0;
`endif
                if (!rx_s) state_next = RX_START;
            end
            RX_START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (clk_cnt == HALF_TICK) begin
                    clk_cnt_next = '0;
                    state_next   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                clk_cnt_next = tick ? '0 : clk_cnt + 1'b1;
                if (tick) begin
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                clk_cnt_next = tick ? '0 : clk_cnt + 1'b1;
                if (tick) begin
                    parity_bad_next = (rx_s != (^shift ^ PARITY_BIT));
                    state_next      = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                clk_cnt_next = tick ? '0 : clk_cnt + 1'b1;
                if (tick) begin
                    if (!rx_s) begin
                        frame_next = 1'b1;
                        state_next = RX_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad) begin
                        perr_next  = 1'b1;
                        state_next = RX_IDLE;
`endif
                    end else begin
                        byte_next     = shift;
                        complete_next = 1'b1;
                        state_next    = RX_IDLE;
                    end
                end
            end
            RX_BREAK: begin
                clk_cnt_next = '0;
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks/bit; parity steps run only with UART_RX_PARITY_EN.
module tb_uart_rx_deserializer;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_byte;
    logic       rx_complete, frame_err, parity_err, busy;

    int vectors = 0;
    int miscompares = 0;
    int complete_cnt = 0;
    int frame_cnt = 0;
    int parity_cnt = 0;
    int parity_total = 0;
    int overlap_cnt = 0;
    logic busy_at_complete = 1'b1;
    logic prev_strobe = 1'b0;
    logic [7:0] captured[$];

    uart_rx_deserializer #(
        .CLOCKS_PER_BIT(CPB),
        .SYNC_STAGES(2),
        .PARITY_ODD(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_in(rx_in),
        .rx_byte(rx_byte),
        .rx_complete(rx_complete),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Strobe monitor sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic strobe;
        strobe = rx_complete | frame_err | parity_err;
        if (rx_complete) begin
            complete_cnt++;
            captured.push_back(rx_byte);
            busy_at_complete = busy;
        end
        if (frame_err) frame_cnt++;
        if (parity_err) begin
            parity_cnt++;
            parity_total++;
        end
        if ((int'(rx_complete) + int'(frame_err) + int'(parity_err)) > 1 || (strobe && prev_strobe))
            overlap_cnt++;
        prev_strobe = strobe;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] peek(input int i);
        if (captured.size() > i) return {24'h0, captured[i]};
        return {24'h0, 8'hxx};
    endfunction

    task automatic clear_counts();
        complete_cnt = 0;
        frame_cnt = 0;
        parity_cnt = 0;
        busy_at_complete = 1'b1;
        captured.delete();
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    initial begin
        // Reset held with the line low.
        reset = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clock);
        check_output("rst_complete", {31'h0, rx_complete}, 32'h0);
        check_output("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check_output("rst_parity_err", {31'h0, parity_err}, 32'h0);
        check_output("rst_rx_byte", {24'h0, rx_byte}, 32'h00);
        check_output("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (10) @(negedge clock);
        check_output("idle_after_rst_busy", {31'h0, busy}, 32'h0);

        $display("[TB] single byte A5");
        clear_counts();
        apply_stimulus(8'hA5, ^8'hA5, 1'b1);
        repeat (20) @(negedge clock);
        check_output("a5_pulses", complete_cnt, 32'd1);
        check_output("a5_byte", peek(0), 32'hA5);
        check_output("a5_busy_at_complete", {31'h0, busy_at_complete}, 32'h0);
        check_output("a5_frame_err", frame_cnt, 32'd0);
        check_output("a5_rx_byte_held", {24'h0, rx_byte}, 32'hA5);

        $display("[TB] back-to-back 00 FF");
        clear_counts();
        apply_stimulus(8'h00, ^8'h00, 1'b1);
        apply_stimulus(8'hFF, ^8'hFF, 1'b1);
        repeat (20) @(negedge clock);
        check_output("b2b_pulses", complete_cnt, 32'd2);
        check_output("b2b_byte0", peek(0), 32'h00);
        check_output("b2b_byte1", peek(1), 32'hFF);
        check_output("b2b_errors", frame_cnt + parity_cnt, 32'd0);

        $display("[TB] start glitch");
        clear_counts();
        rx_in = 1'b0;
        repeat (4) @(negedge clock);
        check_output("glitch_busy_during", {31'h0, busy}, 32'h1);
        rx_in = 1'b1;
        repeat (40) @(negedge clock);
        check_output("glitch_busy_after", {31'h0, busy}, 32'h0);
        check_output("glitch_pulses", complete_cnt + frame_cnt + parity_cnt, 32'd0);
        check_output("glitch_rx_byte", {24'h0, rx_byte}, 32'hFF);

        $display("[TB] framing error 3C");
        clear_counts();
        apply_stimulus(8'h3C, ^8'h3C, 1'b0);
        repeat (40) @(negedge clock);
        check_output("ferr_pulse_cycles", frame_cnt, 32'd1);
        check_output("ferr_no_complete", complete_cnt, 32'd0);
        check_output("ferr_rx_byte", {24'h0, rx_byte}, 32'hFF);
        check_output("ferr_busy_held", {31'h0, busy}, 32'h1);
        rx_in = 1'b1;
        repeat (5) @(negedge clock);
        check_output("ferr_busy_released", {31'h0, busy}, 32'h0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] even parity frames");
        clear_counts();
        apply_stimulus(8'h03, 1'b0, 1'b1);
        repeat (20) @(negedge clock);
        check_output("par_good_pulses", complete_cnt, 32'd1);
        check_output("par_good_byte", peek(0), 32'h03);
        clear_counts();
        apply_stimulus(8'h03, 1'b1, 1'b1);
        repeat (20) @(negedge clock);
        check_output("par_bad_perr", parity_cnt, 32'd1);
        check_output("par_bad_no_complete", complete_cnt, 32'd0);
        check_output("par_bad_rx_byte", {24'h0, rx_byte}, 32'h03);
`else
        check_output("no_parity_err_ever", parity_total, 32'd0);
`endif

        $display("[TB] reset mid-frame");
        clear_counts();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check_output("midrst_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        @(negedge clock);
        check_output("midrst_busy_next", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (300) @(negedge clock);
        check_output("midrst_no_pulses", complete_cnt + frame_cnt + parity_cnt, 32'd0);
        check_output("midrst_rx_byte", {24'h0, rx_byte}, 32'h00);

        check_output("strobe_exclusive", overlap_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
